// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the mem_arb fetch/data memory-port arbiter.
// Build option MEM_ARB_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
package mem_arb_pkg;

    localparam int unsigned AwDefault = 32;
    localparam int unsigned DwDefault = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp
    } state_e;

    typedef enum logic {
        OwnF,
        OwnD
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on contention; otherwise data always beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   f_vld_i,
    input  logic   d_vld_i,
`ifdef MEM_ARB_RR_EN
    input  owner_e last_i,
`endif
    output logic   any_o,
    output owner_e win_o
);

    assign any_o = f_vld_i | d_vld_i;

    always_comb begin
        win_o = OwnF;
`ifdef MEM_ARB_RR_EN
        if (f_vld_i && d_vld_i) begin
            win_o = (last_i == OwnF) ? OwnD : OwnF;
        end else if (d_vld_i) begin
            win_o = OwnD;
        end
`else
        if (d_vld_i) begin
            win_o = OwnD;
        end
`endif
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port between fetch and data paths, one transaction outstanding at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration (builds the last-grant register).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AwDefault,
    parameter int unsigned DW = DwDefault
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            f_req_vld_i,
    output logic            f_req_rdy_o,
    input  logic [AW-1:0]   f_req_addr_i,
    output logic            f_rsp_vld_o,
    input  logic            f_rsp_rdy_i,
    output logic [DW-1:0]   f_rsp_data_o,

    input  logic            d_req_vld_i,
    output logic            d_req_rdy_o,
    input  logic [AW-1:0]   d_req_addr_i,
    input  logic            d_req_wr_i,
    input  logic [DW-1:0]   d_req_wdata_i,
    input  logic [DW/8-1:0] d_req_wstrb_i,
    output logic            d_rsp_vld_o,
    input  logic            d_rsp_rdy_i,
    output logic [DW-1:0]   d_rsp_data_o,

    output logic            m_req_vld_o,
    input  logic            m_req_rdy_i,
    output logic [AW-1:0]   m_req_addr_o,
    output logic            m_req_wr_o,
    output logic [DW-1:0]   m_req_wdata_o,
    output logic [DW/8-1:0] m_req_wstrb_o,
    input  logic            m_rsp_vld_i,
    output logic            m_rsp_rdy_o,
    input  logic [DW-1:0]   m_rsp_data_i
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e win, cur_owner;
    logic   any_req, own_rsp_rdy, rsp_hs, arb_en, m_req_hs;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
`endif

    mem_arb_pick u_pick (
        .f_vld_i (f_req_vld_i),
        .d_vld_i (d_req_vld_i),
`ifdef MEM_ARB_RR_EN
        .last_i  (last_q),
`endif
        .any_o   (any_req),
        .win_o   (win)
    );

    assign own_rsp_rdy = (owner_q == OwnF) ? f_rsp_rdy_i : d_rsp_rdy_i;
    assign rsp_hs      = (state_q == StRsp) && m_rsp_vld_i && own_rsp_rdy;
    // A completing response frees the port, so a new winner may issue in the same cycle.
    assign arb_en      = (state_q == StIdle) || rsp_hs;
    assign cur_owner   = arb_en ? win : owner_q;

    always_comb begin
        m_req_vld_o   = !rst_i && ((arb_en && any_req) || (state_q == StReq));
        m_req_hs      = m_req_vld_o && m_req_rdy_i;
        m_req_addr_o  = '0;
        m_req_wr_o    = 1'b0;
        m_req_wdata_o = '0;
        m_req_wstrb_o = '0;
        if (m_req_vld_o) begin
            if (cur_owner == OwnD) begin
                m_req_addr_o  = d_req_addr_i;
                m_req_wr_o    = d_req_wr_i;
                m_req_wdata_o = d_req_wdata_i;
                m_req_wstrb_o = d_req_wstrb_i;
            end else begin
                m_req_addr_o  = f_req_addr_i;
            end
        end
        f_req_rdy_o  = m_req_hs && (cur_owner == OwnF);
        d_req_rdy_o  = m_req_hs && (cur_owner == OwnD);

        m_rsp_rdy_o  = !rst_i && (state_q == StRsp) && own_rsp_rdy;
        f_rsp_vld_o  = !rst_i && (state_q == StRsp) && (owner_q == OwnF) && m_rsp_vld_i;
        d_rsp_vld_o  = !rst_i && (state_q == StRsp) && (owner_q == OwnD) && m_rsp_vld_i;
        f_rsp_data_o = f_rsp_vld_o ? m_rsp_data_i : '0;
        d_rsp_data_o = d_rsp_vld_o ? m_rsp_data_i : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    owner_d = win;
                    state_d = m_req_rdy_i ? StRsp : StReq;
                end
            end
            StReq: begin
                if (m_req_rdy_i) begin
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (rsp_hs) begin
                    if (any_req) begin
                        owner_d = win;
                        state_d = m_req_rdy_i ? StRsp : StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MEM_ARB_RR_EN
    assign last_d = m_req_hs ? cur_owner : last_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            owner_q <= OwnF;
`ifdef MEM_ARB_RR_EN
            last_q  <= OwnD;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios, then random traffic with a scoreboard.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_vld, f_req_rdy, f_rsp_vld, f_rsp_rdy;
    logic [31:0] f_req_addr, f_rsp_data;
    logic        d_req_vld, d_req_rdy, d_req_wr, d_rsp_vld, d_rsp_rdy;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [3:0]  d_req_wstrb;
    logic        m_req_vld, m_req_rdy, m_req_wr, m_rsp_vld, m_rsp_rdy;
    logic [31:0] m_req_addr, m_req_wdata, m_rsp_data;
    logic [3:0]  m_req_wstrb;

    int n_chk  = 0;
    int n_pass = 0;
    bit sb_en  = 1'b0;

`ifdef MEM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    mem_arb #(.AW(32), .DW(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .f_req_vld_i   (f_req_vld),
        .f_req_rdy_o   (f_req_rdy),
        .f_req_addr_i  (f_req_addr),
        .f_rsp_vld_o   (f_rsp_vld),
        .f_rsp_rdy_i   (f_rsp_rdy),
        .f_rsp_data_o  (f_rsp_data),
        .d_req_vld_i   (d_req_vld),
        .d_req_rdy_o   (d_req_rdy),
        .d_req_addr_i  (d_req_addr),
        .d_req_wr_i    (d_req_wr),
        .d_req_wdata_i (d_req_wdata),
        .d_req_wstrb_i (d_req_wstrb),
        .d_rsp_vld_o   (d_rsp_vld),
        .d_rsp_rdy_i   (d_rsp_rdy),
        .d_rsp_data_o  (d_rsp_data),
        .m_req_vld_o   (m_req_vld),
        .m_req_rdy_i   (m_req_rdy),
        .m_req_addr_o  (m_req_addr),
        .m_req_wr_o    (m_req_wr),
        .m_req_wdata_o (m_req_wdata),
        .m_req_wstrb_o (m_req_wstrb),
        .m_rsp_vld_i   (m_rsp_vld),
        .m_rsp_rdy_o   (m_rsp_rdy),
        .m_rsp_data_i  (m_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    // Bench memory contents: every address reads back a distinct, address-derived word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic clr_in();
        f_req_vld = 0; f_req_addr = '0; f_rsp_rdy = 0;
        d_req_vld = 0; d_req_addr = '0; d_req_wr = 0; d_req_wdata = '0; d_req_wstrb = '0;
        d_rsp_rdy = 0; m_req_rdy = 0; m_rsp_vld = 0; m_rsp_data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        #1;
        chk({name, " ctl"}, {26'd0, f_req_rdy, f_rsp_vld, d_req_rdy, d_rsp_vld, m_req_vld,
            m_rsp_rdy}, 32'd0);
        chk({name, " data"}, f_rsp_data | d_rsp_data | m_req_addr | m_req_wdata |
            {27'd0, m_req_wr, m_req_wstrb}, 32'd0);
    endtask

    // Scoreboard: expectations are pushed when a requester's request is accepted.
    logic [31:0] exp_f[$];
    logic [31:0] exp_d[$];
    bit          exp_dwr[$];

    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] prev_addr, prev_wdata;
        logic [4:0]  prev_ctl;
        bit          last_d = 1'b1;
        bit          exp_win_d;
        logic [31:0] e;
        bit          w;
        forever begin
            @(negedge clk);
            if (sb_en && !rst) begin
                if (f_req_vld && f_req_rdy) exp_f.push_back(mem_fn(f_req_addr));
                if (d_req_vld && d_req_rdy) begin
                    exp_d.push_back(mem_fn(d_req_addr));
                    exp_dwr.push_back(d_req_wr);
                end
                if (f_rsp_vld && f_rsp_rdy) begin
                    if (exp_f.size() == 0) chkb("f_rsp unexpected", 1'b1, 1'b0);
                    else begin
                        e = exp_f.pop_front();
                        chk("f_rsp_data", f_rsp_data, e);
                    end
                end
                if (d_rsp_vld && d_rsp_rdy) begin
                    if (exp_d.size() == 0) chkb("d_rsp unexpected", 1'b1, 1'b0);
                    else begin
                        e = exp_d.pop_front();
                        w = exp_dwr.pop_front();
                        if (!w) chk("d_rsp_data", d_rsp_data, e);
                    end
                end
                chkb("rsp exclusive", f_rsp_vld & d_rsp_vld, 1'b0);
                if (prev_stall) begin
                    chkb("stall m_req_vld", m_req_vld, 1'b1);
                    chk("stall addr", m_req_addr, prev_addr);
                    chk("stall wdata", m_req_wdata, prev_wdata);
                    chk("stall wr/wstrb", 32'({m_req_wr, m_req_wstrb}), 32'(prev_ctl));
                end else if (m_req_vld && f_req_vld && d_req_vld) begin
                    exp_win_d = RrEn ? !last_d : 1'b1;
                    chkb("arb winner is data", m_req_addr[31], exp_win_d);
                end
                if (m_req_vld && m_req_rdy) begin
                    chk("one req_rdy", 32'(f_req_rdy) + 32'(d_req_rdy), 32'd1);
                    if (d_req_rdy) begin
                        chk("d payload addr", m_req_addr, d_req_addr);
                        chk("d payload wdata", m_req_wdata, d_req_wdata);
                        chk("d payload wr/wstrb", 32'({m_req_wr, m_req_wstrb}),
                            32'({d_req_wr, d_req_wstrb}));
                    end
                    if (f_req_rdy) begin
                        chk("f payload addr", m_req_addr, f_req_addr);
                        chk("f payload wr/wstrb", 32'({m_req_wr, m_req_wstrb}), 32'd0);
                    end
                    last_d = d_req_rdy;
                end
                prev_stall = m_req_vld && !m_req_rdy;
                prev_addr  = m_req_addr;
                prev_wdata = m_req_wdata;
                prev_ctl   = {m_req_wr, m_req_wstrb};
            end
        end
    end

    task automatic rand_phase(input int ncyc, input int ndrain);
        logic        fh, dh, mh, mrh, drain;
        logic [31:0] s_maddr, paddr;
        bit          pend;
        int          lat;
        pend  = 0;
        lat   = 0;
        paddr = '0;
        for (int c = 0; c < ncyc + ndrain; c++) begin
            drain = (c >= ncyc);
            @(negedge clk);
            fh      = f_req_vld & f_req_rdy;
            dh      = d_req_vld & d_req_rdy;
            mh      = m_req_vld & m_req_rdy;
            mrh     = m_rsp_vld & m_rsp_rdy;
            s_maddr = m_req_addr;
            @(posedge clk);
            #1;
            if (!f_req_vld || fh) begin
                f_req_vld  = !drain && ($urandom_range(0, 2) != 0);
                f_req_addr = $urandom() & 32'h7FFF_FFFC;
            end
            if (!d_req_vld || dh) begin
                d_req_vld   = !drain && ($urandom_range(0, 1) != 0);
                d_req_addr  = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
                d_req_wr    = 1'($urandom_range(0, 1));
                d_req_wdata = $urandom();
                d_req_wstrb = 4'($urandom_range(0, 15));
            end
            f_rsp_rdy = drain || ($urandom_range(0, 3) != 0);
            d_rsp_rdy = drain || ($urandom_range(0, 3) != 0);
            m_req_rdy = drain || ($urandom_range(0, 2) != 0);
            if (mrh) pend = 0;
            if (mh) begin
                pend  = 1;
                paddr = s_maddr;
                lat   = $urandom_range(0, 2);
            end else if (pend && lat > 0) begin
                lat--;
            end
            if (pend) begin
                m_rsp_vld  = (lat == 0);
                m_rsp_data = mem_fn(paddr);
            end else begin
                m_rsp_vld  = ($urandom_range(0, 4) == 0);
                m_rsp_data = $urandom();
            end
        end
    endtask

    initial begin
        logic [31:0] w_addr, l_addr;
        bit          f_first;
        clr_in();
        rst = 1'b1;

        // Reset state and single fetch.
        do_reset();
        chk_all_zero("reset");
        cyc();
        f_req_vld = 1; f_req_addr = 32'h100; m_req_rdy = 1;
        #1;
        chkb("fetch m_req_vld", m_req_vld, 1'b1);
        chk("fetch m_req_addr", m_req_addr, 32'h100);
        chkb("fetch m_req_wr", m_req_wr, 1'b0);
        chkb("fetch f_req_rdy", f_req_rdy, 1'b1);
        cyc();
        f_req_vld = 0; m_req_rdy = 0; m_rsp_vld = 1; m_rsp_data = 32'h13;
        f_rsp_rdy = 1; d_rsp_rdy = 1;
        #1;
        chkb("fetch f_rsp_vld", f_rsp_vld, 1'b1);
        chk("fetch f_rsp_data", f_rsp_data, 32'h13);
        chkb("fetch d_rsp_vld", d_rsp_vld, 1'b0);
        chkb("fetch m_rsp_rdy", m_rsp_rdy, 1'b1);
        cyc();
        m_rsp_vld = 0;
        #1;
        chkb("fetch idle m_req_vld", m_req_vld, 1'b0);

        // Contention: RR after reset grants fetch first, fixed priority grants data first.
        do_reset();
        f_req_vld = 1; f_req_addr = 32'h300;
        d_req_vld = 1; d_req_addr = 32'h2000; d_req_wr = 1;
        d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
        m_req_rdy = 1; f_rsp_rdy = 1; d_rsp_rdy = 1;
        f_first = RrEn;
        w_addr  = f_first ? 32'h300 : 32'h2000;
        l_addr  = f_first ? 32'h2000 : 32'h300;
        #1;
        chk("cont1 addr", m_req_addr, w_addr);
        chkb("cont1 f_req_rdy", f_req_rdy, f_first);
        chkb("cont1 d_req_rdy", d_req_rdy, !f_first);
        if (!f_first) chk("cont1 wdata", m_req_wdata, 32'hDEAD_BEEF);
        cyc();
        if (f_first) f_req_vld = 0; else d_req_vld = 0;
        m_rsp_vld = 1; m_rsp_data = 32'h1111_1111;
        #1;
        chkb("cont2 f_rsp_vld", f_rsp_vld, f_first);
        chkb("cont2 d_rsp_vld", d_rsp_vld, !f_first);
        chkb("cont2 b2b m_req_vld", m_req_vld, 1'b1);
        chk("cont2 addr", m_req_addr, l_addr);
        chkb("cont2 loser rdy", f_first ? d_req_rdy : f_req_rdy, 1'b1);
        cyc();
        f_req_vld = 0; d_req_vld = 0; m_rsp_data = 32'h2222_2222;
        #1;
        chkb("cont3 f_rsp_vld", f_rsp_vld, !f_first);
        chkb("cont3 d_rsp_vld", d_rsp_vld, f_first);
        chkb("cont3 m_req_vld", m_req_vld, 1'b0);

        // Stall: owner stays locked while data toggles its valid.
        do_reset();
        f_req_vld = 1; f_req_addr = 32'h400;
        d_req_addr = 32'h2000; d_req_wr = 1; d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            d_req_vld = (i == 1);
            #1;
            chkb("stall vld", m_req_vld, 1'b1);
            chk("stall held addr", m_req_addr, 32'h400);
            chk("stall held wr/wstrb", 32'({m_req_wr, m_req_wstrb}), 32'd0);
            chkb("stall no rdy", f_req_rdy | d_req_rdy, 1'b0);
        end
        cyc();
        d_req_vld = 1; m_req_rdy = 1;
        #1;
        chkb("stall accept f", f_req_rdy, 1'b1);
        chkb("stall accept d", d_req_rdy, 1'b0);
        chk("stall accept addr", m_req_addr, 32'h400);

        // Back-to-back fetches at one transaction per cycle.
        do_reset();
        f_rsp_rdy = 1; m_req_rdy = 1; f_req_vld = 1; f_req_addr = 32'h0;
        #1;
        chkb("b2b first rdy", f_req_rdy, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            m_rsp_vld = 1; m_rsp_data = mem_fn(32'(4 * (i - 1)));
            if (i < 8) f_req_addr = 32'(4 * i);
            else f_req_vld = 0;
            #1;
            chkb("b2b f_rsp_vld", f_rsp_vld, 1'b1);
            chk("b2b f_rsp_data", f_rsp_data, mem_fn(32'(4 * (i - 1))));
            chkb("b2b m_req_vld", m_req_vld, i < 8);
            if (i < 8) begin
                chk("b2b m_req_addr", m_req_addr, 32'(4 * i));
                chkb("b2b f_req_rdy", f_req_rdy, 1'b1);
            end
        end

        // Response backpressure blocks completion and the next issue.
        do_reset();
        f_req_vld = 1; f_req_addr = 32'h500; m_req_rdy = 1;
        #1;
        chkb("bp first rdy", f_req_rdy, 1'b1);
        cyc();
        f_req_addr = 32'h504; m_rsp_vld = 1; m_rsp_data = 32'h55; f_rsp_rdy = 0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) cyc();
            #1;
            chkb("bp m_rsp_rdy", m_rsp_rdy, 1'b0);
            chkb("bp m_req_vld", m_req_vld, 1'b0);
            chkb("bp f_req_rdy", f_req_rdy, 1'b0);
            chkb("bp f_rsp_vld", f_rsp_vld, 1'b1);
        end
        cyc();
        f_rsp_rdy = 1;
        #1;
        chkb("bp release m_rsp_rdy", m_rsp_rdy, 1'b1);
        chk("bp release data", f_rsp_data, 32'h55);
        chk("bp release addr", m_req_addr, 32'h504);
        chkb("bp release f_req_rdy", f_req_rdy, 1'b1);

        // Reset while a response is outstanding.
        do_reset();
        f_req_vld = 1; f_req_addr = 32'h600; m_req_rdy = 1;
        #1;
        chkb("rst-rsp issue", f_req_rdy, 1'b1);
        cyc();
        f_req_vld = 0; m_req_rdy = 0; rst = 1;
        cyc();
        rst = 0;
        chk_all_zero("rst-rsp");
        cyc();
        m_rsp_vld = 1; m_rsp_data = 32'h77; f_rsp_rdy = 1; d_rsp_rdy = 1;
        #1;
        chkb("spurious f_rsp_vld", f_rsp_vld, 1'b0);
        chkb("spurious d_rsp_vld", d_rsp_vld, 1'b0);
        chkb("spurious m_rsp_rdy", m_rsp_rdy, 1'b0);

        // Random traffic against the scoreboard.
        do_reset();
        sb_en = 1'b1;
        rand_phase(3000, 40);
        @(negedge clk);
        sb_en = 1'b0;
        chk("fetch responses drained", exp_f.size(), 32'd0);
        chk("data responses drained", exp_d.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter sharing the core's single memory port between the instruction-fetch path (IFU) and the data load/store path. It grants one requester at a time, keeps at most one transaction outstanding, and routes each response back to the requester that issued it. All channels use the core's valid/ready handshake. It sits between the IFU/LSU and the memory bus adapter.

## Interface

- AW, 32, address width
- DW, 32, data width (write-strobe width is DW/8)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- f_req_vld  in  1  fetch request valid
- f_req_rdy  out  1  fetch request ready
- f_req_addr  in  AW  fetch address
- f_rsp_vld  out  1  fetch response valid
- f_rsp_rdy  in  1  fetch response ready
- f_rsp_data  out  DW  fetch response data
- d_req_vld / d_req_rdy  in / out  1  data request handshake
- d_req_addr  in  AW  data address
- d_req_wr  in  1  1 = write, 0 = read
- d_req_wdata  in  DW  write data
- d_req_wstrb  in  DW/8  byte strobes
- d_rsp_vld / d_rsp_rdy  out / in  1  data response handshake
- d_rsp_data  out  DW  read data (don't-care for writes)
- m_req_vld / m_req_rdy  out / in  1  memory request handshake
- m_req_addr, m_req_wr, m_req_wdata, m_req_wstrb  out  AW, 1, DW, DW/8  memory request payload (wr = 0, wstrb = 0 for fetch)
- m_rsp_vld / m_rsp_rdy  in / out  1  memory response handshake
- m_rsp_data  in  DW  memory response data

## Operation

- FSM states: IDLE (nothing presented, nothing outstanding), REQ (request presented, not yet accepted; grant locked), RSP (one request outstanding).
- Owner register (F/D) records the grant. A last-grant pointer feeds round-robin.
- IDLE:
  - If any req_vld is high, the picker chooses a winner and its payload drives m_req_* combinationally. m_req_vld = 1 in the same cycle.
  - On m_req handshake, the winner's req_rdy is high that cycle and the FSM moves to RSP. Otherwise it moves to REQ with the owner latched.
- REQ: m_req_* continues to come from the latched owner regardless of the other requester. Stay until m_req_rdy, then go to RSP.
- RSP:
  - m_rsp_rdy = the owner's rsp_rdy. Only the owner's rsp_vld may be high: rsp_vld = m_rsp_vld, rsp_data = m_rsp_data.
  - On response handshake, if any req_vld is high, arbitrate and issue in the same cycle (back-to-back). Then go to RSP or REQ depending on m_req_rdy. Otherwise go to IDLE.
- A requester's req_rdy is high only when it is the winner and m_req_rdy is high, and only when not in RSP without a response handshake that cycle.
- When no transaction is outstanding, m_rsp_rdy = 0 and m_rsp_vld is ignored.
- Writes also receive exactly one response.
- Reset: FSM = IDLE, owner = F, last-grant = D. All outputs are 0: req_rdy, rsp_vld, m_req_vld, m_rsp_rdy, and all data outputs.
- A reset asserted mid-transaction drops the outstanding transaction. The memory side is reset in the same domain.

## Timing

- Request path has zero latency: requester to m_req is combinational. Response path has zero latency: m_rsp to requester is combinational.
- No combinational path from m_req_rdy to m_req_vld. Path m_rsp_vld & rsp_rdy → m_req_vld is permitted (back-to-back).
- Throughput: one transaction per cycle when memory responds in the cycle after acceptance.
- m_req payload is stable while m_req_vld is high and m_req_rdy is low.

## Configuration

- MEM_ARB_RR_EN defined: round-robin arbitration. On contention the requester not granted last wins. Last-grant updates on every m_req handshake.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. The last-grant register is not built.

## Structure

- Package mem_arb_pkg holds:
  - the state enum (IDLE/REQ/RSP)
  - the owner enum (F/D)
  - default widths
- Sub-module mem_arb_pick: combinational winner selection from the two valids and last-grant, with the MEM_ARB_RR_EN variants inside.
- The FSM, owner register and muxes live in mem_arb.

## Test plan

- Fetch only: f_req_addr = 0x100, memory ready, response 0x00000013 next cycle → m_req_addr = 0x100, wr = 0; f_rsp_data = 0x00000013; d_rsp_vld stays 0.
- Contention: both valid, d_req_addr = 0x2000 write, wdata = 0xDEADBEEF, wstrb = 0xF.
  - With RR after reset → fetch wins first, data second.
  - Without RR → data wins first.
- Stall: m_req_rdy = 0 for 3 cycles while the other requester toggles valid → m_req_* held constant on the latched owner; accepted on the 4th cycle.
- Back-to-back: response handshake and a new f_req in the same cycle → new m_req_vld in that cycle. Sustained one transaction per cycle over 8 fetches with addresses 0x0..0x1C.
- Response backpressure: f_rsp_rdy = 0 for 2 cycles → m_rsp_rdy = 0, no new m_req issued; completes when ready rises.
- Reset in RSP: assert rst one cycle → all outputs 0 next cycle, FSM IDLE; a spurious m_rsp_vld afterwards is ignored.
